// File: rtl/tdoa_if.sv
// Detector/processor-side signal bundle for tdoa_collector.
// The master drives detections and ack; the collector (slave) returns the result set.
interface tdoa_if;
    logic [3:0]   det_valid;
    logic [127:0] det_time;
    logic         ack;
    logic         res_valid;
    logic [31:0]  res_time0;
    logic [95:0]  res_diff;
    logic         busy;

    modport master (
        output det_valid, det_time, ack,
        input  res_valid, res_time0, res_diff, busy
    );

    modport slave (
        input  det_valid, det_time, ack,
        output res_valid, res_time0, res_diff, busy
    );
endinterface

// File: rtl/tdoa_collector.sv
// Gathers one timestamp per microphone channel inside a timeout window and presents TDOAs vs channel 0.
// Optional macro TDOA_DROP_CNT_EN adds a saturating count of timed-out windows on drop_cnt.
module tdoa_collector #(
    parameter int unsigned NUM_CH = 4,
    parameter logic [31:0] WINDOW = 32'd50000,
    parameter int unsigned TW     = 32
) (
    input  logic        clk,
    input  logic        rst,
    tdoa_if.slave       bus
`ifdef TDOA_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUTPUT} state_t;

    state_t                     state_q, state_d;
    logic [NUM_CH-1:0]          mask_q, mask_d, mask_cap;
    logic [NUM_CH-1:0][TW-1:0]  time_q, time_d;
    logic [31:0]                cnt_q, cnt_d;
    logic                       res_valid_q, res_valid_d;
    logic [TW-1:0]              res_time0_q, res_time0_d;
    logic [(NUM_CH-1)*TW-1:0]   res_diff_q, res_diff_d;
    logic                       complete, timeout;
`ifdef TDOA_DROP_CNT_EN
    logic [15:0]                drop_q, drop_d;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Capture: completion is judged on the mask including this cycle's arrivals,
    // so a last channel landing on the timeout cycle still completes the set.
    always_comb begin
        mask_cap = mask_q;
        time_d   = time_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.det_valid) cnt_d = '0;
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (bus.det_valid[k]) begin
                        mask_cap[k] = 1'b1;
                        time_d[k]   = bus.det_time[TW*k +: TW];
                    end
                end
            end
            S_COLLECT: begin
                cnt_d = cnt_q + 32'd1;
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (bus.det_valid[k] && !mask_q[k]) begin
                        mask_cap[k] = 1'b1;
                        time_d[k]   = bus.det_time[TW*k +: TW];
                    end
                end
            end
            default: ;
        endcase
        complete = (state_q != S_OUTPUT) && (&mask_cap);
        timeout  = (state_q == S_COLLECT) && (cnt_q == WINDOW - 32'd1) && !(&mask_cap);
        mask_d   = (complete || timeout) ? '0 : mask_cap;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (complete)            state_d = S_OUTPUT;
                else if (|bus.det_valid) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (complete)     state_d = S_OUTPUT;
                else if (timeout) state_d = S_IDLE;
            end
            S_OUTPUT: begin
                if (bus.ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result computation, two's-complement wrap is intentional
    always_comb begin
        res_valid_d = res_valid_q;
        res_time0_d = res_time0_q;
        res_diff_d  = res_diff_q;
        if (complete) begin
            res_valid_d = 1'b1;
            res_time0_d = time_d[0];
            for (int unsigned k = 1; k < NUM_CH; k++)
                res_diff_d[TW*(k-1) +: TW] = time_d[k] - time_d[0];
        end else if (state_q == S_OUTPUT && bus.ack) begin
            res_valid_d = 1'b0;
        end
    end

`ifdef TDOA_DROP_CNT_EN
    always_comb begin
        drop_d = drop_q;
        if (timeout && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q      <= '0;
            time_q      <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_time0_q <= '0;
            res_diff_q  <= '0;
`ifdef TDOA_DROP_CNT_EN
            drop_q      <= '0;
`endif
        end else begin
            mask_q      <= mask_d;
            time_q      <= time_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_time0_q <= res_time0_d;
            res_diff_q  <= res_diff_d;
`ifdef TDOA_DROP_CNT_EN
            drop_q      <= drop_d;
`endif
        end
    end

    // Output logic
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.res_valid = res_valid_q;
        bus.res_time0 = res_time0_q;
        bus.res_diff  = res_diff_q;
`ifdef TDOA_DROP_CNT_EN
        drop_cnt      = drop_q;
`endif
    end

endmodule

// File: tb/tb_tdoa_collector.sv
// Directed self-checking bench for tdoa_collector with a shortened collection window.
module tb_tdoa_collector;
    localparam logic [31:0] W = 32'd20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    tdoa_if bus ();
`ifdef TDOA_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    tdoa_collector #(.WINDOW(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef TDOA_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v, input logic [31:0] t3, input logic [31:0] t2,
                         input logic [31:0] t1, input logic [31:0] t0);
        bus.det_valid = v;
        bus.det_time  = {t3, t2, t1, t0};
        tick();
        bus.det_valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.det_valid = '0;
        bus.det_time  = '0;
        bus.ack       = 1'b0;
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_ctrl: valid=%b busy=%b, want 0 0", bus.res_valid, bus.busy);
        end
        n_cmp++;
        if (bus.res_time0 !== 32'd0 || bus.res_diff !== 96'd0) begin
            n_bad++; $display("FAIL reset_data: t0=%h diff=%h, want 0", bus.res_time0, bus.res_diff);
        end
`ifdef TDOA_DROP_CNT_EN
        n_cmp++;
        if (drop_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt);
        end
`endif
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        pulse(4'b0001, 0, 0, 0, 32'd1000);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
            n_bad++; $display("FAIL seq_busy: busy=%b valid=%b, want 1 0", bus.busy, bus.res_valid);
        end
        pulse(4'b0010, 0, 0, 32'd1010, 0);
        pulse(4'b0100, 0, 32'd995, 0, 0);
        n_cmp++;
        if (bus.res_valid !== 1'b0) begin
            n_bad++; $display("FAIL seq_early: valid=%b want 0", bus.res_valid);
        end
        pulse(4'b1000, 32'd1040, 0, 0, 0);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_time0 !== 32'd1000 ||
            bus.res_diff !== {32'd40, 32'hFFFFFFFB, 32'd10}) begin
            n_bad++; $display("FAIL seq_result: valid=%b t0=%0d diff=%h, want 1 1000 %h",
                              bus.res_valid, bus.res_time0, bus.res_diff, {32'd40, 32'hFFFFFFFB, 32'd10});
        end
        repeat (3) tick();
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_diff !== {32'd40, 32'hFFFFFFFB, 32'd10}) begin
            n_bad++; $display("FAIL seq_hold: valid=%b diff=%h, want held", bus.res_valid, bus.res_diff);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL seq_ack: valid=%b busy=%b, want 0 0", bus.res_valid, bus.busy);
        end
    endtask

    task automatic test_simultaneous_and_output_ignore();
        pulse(4'b1111, 32'd5, 32'd9, 32'd7, 32'd7);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_time0 !== 32'd7 ||
            bus.res_diff !== {32'hFFFFFFFE, 32'd2, 32'd0}) begin
            n_bad++; $display("FAIL simul_result: valid=%b t0=%0d diff=%h, want 1 7 %h",
                              bus.res_valid, bus.res_time0, bus.res_diff, {32'hFFFFFFFE, 32'd2, 32'd0});
        end
        pulse(4'b1111, 32'd100, 32'd200, 32'd300, 32'd400);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_time0 !== 32'd7 ||
            bus.res_diff !== {32'hFFFFFFFE, 32'd2, 32'd0}) begin
            n_bad++; $display("FAIL output_ignore: t0=%0d diff=%h, want 7 unchanged", bus.res_time0, bus.res_diff);
        end
        bus.ack = 1'b1;
        pulse(4'b0001, 0, 0, 0, 32'd55);
        bus.ack = 1'b0;
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL ack_cycle_pulse: valid=%b busy=%b, want 0 0", bus.res_valid, bus.busy);
        end
    endtask

    task automatic test_timeout();
        pulse(4'b0001, 0, 0, 0, 32'd1);
        pulse(4'b0010, 0, 0, 32'd2, 0);
        pulse(4'b0100, 0, 32'd3, 0, 0);
        repeat (W - 3) tick();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL timeout_early: busy=%b want 1", bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            n_bad++; $display("FAIL timeout_idle: busy=%b valid=%b, want 0 0", bus.busy, bus.res_valid);
        end
`ifdef TDOA_DROP_CNT_EN
        n_cmp++;
        if (drop_cnt !== 16'd1) begin
            n_bad++; $display("FAIL timeout_drop: got %0d want 1", drop_cnt);
        end
`endif
    endtask

    task automatic test_boundary();
        pulse(4'b0001, 0, 0, 0, 32'd100);
        pulse(4'b0010, 0, 0, 32'd110, 0);
        pulse(4'b0100, 0, 32'd120, 0, 0);
        repeat (W - 3) tick();
        pulse(4'b1000, 32'd130, 0, 0, 0);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_time0 !== 32'd100 ||
            bus.res_diff !== {32'd30, 32'd20, 32'd10}) begin
            n_bad++; $display("FAIL boundary_complete: valid=%b t0=%0d diff=%h, want 1 100 %h",
                              bus.res_valid, bus.res_time0, bus.res_diff, {32'd30, 32'd20, 32'd10});
        end
`ifdef TDOA_DROP_CNT_EN
        n_cmp++;
        if (drop_cnt !== 16'd1) begin
            n_bad++; $display("FAIL boundary_drop: got %0d want 1", drop_cnt);
        end
`endif
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_wrap();
        pulse(4'b0001, 0, 0, 0, 32'hFFFFFFF0);
        pulse(4'b0010, 0, 0, 32'h00000010, 0);
        pulse(4'b1100, 32'h00000000, 32'hFFFFFFF8, 0, 0);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_diff !== {32'h00000010, 32'h00000008, 32'h00000020}) begin
            n_bad++; $display("FAIL wrap_diff: valid=%b diff=%h, want 1 %h",
                              bus.res_valid, bus.res_diff, {32'h00000010, 32'h00000008, 32'h00000020});
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_repeat();
        pulse(4'b0010, 0, 0, 32'd50, 0);
        pulse(4'b0010, 0, 0, 32'd99, 0);
        pulse(4'b0001, 0, 0, 0, 32'd40);
        pulse(4'b1100, 32'd70, 32'd60, 0, 0);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_time0 !== 32'd40 ||
            bus.res_diff !== {32'd30, 32'd20, 32'd10}) begin
            n_bad++; $display("FAIL repeat_first_wins: valid=%b t0=%0d diff=%h, want 1 40 %h",
                              bus.res_valid, bus.res_time0, bus.res_diff, {32'd30, 32'd20, 32'd10});
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse(4'b0001, 0, 0, 0, 32'd500);
        pulse(4'b0010, 0, 0, 32'd600, 0);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: busy=%b valid=%b, want 0 0", bus.busy, bus.res_valid);
        end
        rst = 1'b1;
        tick();
        pulse(4'b1100, 32'd13, 32'd12, 0, 0);
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL reset_discard: valid=%b busy=%b, want 0 1", bus.res_valid, bus.busy);
        end
        pulse(4'b0011, 0, 0, 32'd11, 32'd10);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_time0 !== 32'd10 ||
            bus.res_diff !== {32'd3, 32'd2, 32'd1}) begin
            n_bad++; $display("FAIL reset_newset: valid=%b t0=%0d diff=%h, want 1 10 %h",
                              bus.res_valid, bus.res_time0, bus.res_diff, {32'd3, 32'd2, 32'd1});
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_simultaneous_and_output_ignore();
        test_timeout();
        test_boundary();
        test_wrap();
        test_repeat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
